// File: rtl/hazard_scoreboard.sv
// Hazard unit beside decode: in-flight write scoreboard, operand forwarding
// selects, load-use stalls, redirect flush sequencing and stall counting.
module hazard_scoreboard #(
    parameter int NUM_STAGES   = 3,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int REG_W        = 5,
    parameter int SEL_W        = $clog2(NUM_STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_wr,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    output logic [SEL_W-1:0] fwd_sel_a,
    output logic [SEL_W-1:0] fwd_sel_b,
    output logic             stall,
    output logic             flush,
    output logic             busy_flush,
    output logic [31:0]      stall_cnt
);

    localparam int CTR_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'(FLUSH_CYCLES - 1);

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             ld;
    } sb_entry_t;

    typedef struct packed {
        logic             hit;
        logic             rdy;
        logic [SEL_W-1:0] sel;
    } match_t;

    typedef enum logic {
        S_RUN,
        S_FLUSH
    } state_e;

    sb_entry_t [NUM_STAGES:1] sb_q, sb_d;
    state_e                   state_q, state_d;
    logic [CTR_W-1:0]         ctr_q, ctr_d;
    logic [31:0]              cnt_q, cnt_d;

    logic   id_live;
    logic   in_run;
    match_t m_a, m_b;

    // Scan oldest to youngest so the youngest matching producer wins.
    function automatic match_t lookup(
        input sb_entry_t [NUM_STAGES:1] sb,
        input logic [REG_W-1:0]         rs,
        input logic                     used,
        input logic                     live
    );
        match_t m;
        m = '0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (sb[k].v && sb[k].rd == rs && rs != '0 && used && live) begin
                m.hit = 1'b1;
                m.sel = SEL_W'(k);
                m.rdy = !sb[k].ld || (k >= 1 + LOAD_LAT);
            end
        end
        return m;
    endfunction

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        unique case (state_q)
            S_RUN: begin
                if (ex_redirect) begin
                    state_d = S_FLUSH;
                    ctr_d   = CTR_LOAD;
                end
            end
            S_FLUSH: begin
                if (ex_redirect) begin
                    ctr_d = CTR_LOAD;
                end else if (ctr_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    ctr_d = ctr_q - 1'b1;
                end
            end
            default: begin
                state_d = S_RUN;
                ctr_d   = '0;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_run     = (state_q == S_RUN);
        flush      = ex_redirect | (state_q == S_FLUSH);
        busy_flush = (state_q == S_FLUSH);
    end

    assign id_live = id_valid & in_run;

    always_comb begin
        m_a = lookup(sb_q, id_rs1, id_rs1_used, id_live);
        m_b = lookup(sb_q, id_rs2, id_rs2_used, id_live);
    end

    always_comb begin
        stall = ((m_a.hit & ~m_a.rdy) | (m_b.hit & ~m_b.rdy))
              & in_run & ~ex_redirect;
        fwd_sel_a = '0;
        fwd_sel_b = '0;
        if (!stall && !flush) begin
            if (m_a.hit && m_a.rdy) fwd_sel_a = m_a.sel;
            if (m_b.hit && m_b.rdy) fwd_sel_b = m_b.sel;
        end
    end

    // A stalled or flushed ID slot enters EX as a bubble.
    always_comb begin
        sb_d = '0;
        if (id_valid && id_reg_wr && id_rd != '0 && !stall && !flush) begin
            sb_d[1].v  = 1'b1;
            sb_d[1].rd = id_rd;
            sb_d[1].ld = id_is_load;
        end
        for (int k = 2; k <= NUM_STAGES; k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed instruction stream, expectations
// queued per cycle and checked by an independent negedge monitor.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used;
    logic        id_reg_wr, id_is_load, ex_redirect;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic        stall, flush, busy_flush;
    logic [31:0] stall_cnt;

    hazard_scoreboard #(
        .NUM_STAGES  (3),
        .LOAD_LAT    (1),
        .FLUSH_CYCLES(2),
        .REG_W       (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used),
        .id_rd      (id_rd),
        .id_reg_wr  (id_reg_wr),
        .id_is_load (id_is_load),
        .ex_redirect(ex_redirect),
        .fwd_sel_a  (fwd_sel_a),
        .fwd_sel_b  (fwd_sel_b),
        .stall      (stall),
        .flush      (flush),
        .busy_flush (busy_flush),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        int          cyc;
        logic [1:0]  a;
        logic [1:0]  b;
        logic        st;
        logic        fl;
        logic        bf;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (e.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d still pending at cycle %0d",
                         e.nm, e.cyc, cyc);
            end else if ({fwd_sel_a, fwd_sel_b, stall, flush, busy_flush, stall_cnt}
                         !== {e.a, e.b, e.st, e.fl, e.bf, e.cnt}) begin
                n_bad++;
                $display("FAIL %s: got a=%0d b=%0d stall=%b flush=%b busy=%b cnt=%0d, want a=%0d b=%0d stall=%b flush=%b busy=%b cnt=%0d",
                         e.nm, fwd_sel_a, fwd_sel_b, stall, flush, busy_flush, stall_cnt,
                         e.a, e.b, e.st, e.fl, e.bf, e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2,
                         input logic [4:0] rd, input logic wr, input logic ld,
                         input logic rdr);
        id_valid    = v;
        id_rs1      = r1;
        id_rs1_used = u1;
        id_rs2      = r2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_reg_wr   = wr;
        id_is_load  = ld;
        ex_redirect = rdr;
    endtask

    task automatic expect_o(input string nm, input logic [1:0] a, input logic [1:0] b,
                            input logic st, input logic fl, input logic bf,
                            input int cnt);
        exp_t x;
        x.nm  = nm;
        x.cyc = cyc;
        x.a   = a;
        x.b   = b;
        x.st  = st;
        x.fl  = fl;
        x.bf  = bf;
        x.cnt = 32'(cnt);
        exp_q.push_back(x);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_o("reset", 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        expect_o("idle", 0, 0, 0, 0, 0, 0);

        // ALU -> ALU forwarding
        tick(); drive(1, 1, 1, 2, 1, 5, 1, 0, 0);
        expect_o("alu_prod", 0, 0, 0, 0, 0, 0);
        tick(); drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
        expect_o("alu_fwd1", 1, 0, 0, 0, 0, 0);
        tick(); drive(1, 5, 1, 0, 1, 10, 1, 0, 0);
        expect_o("alu_fwd2", 2, 0, 0, 0, 0, 0);
        tick(); drive(0, 5, 1, 6, 1, 0, 0, 0, 0);
        expect_o("id_invalid", 0, 0, 0, 0, 0, 0);

        // Load-use: one stall, then forward from stage 2
        tick(); drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
        expect_o("lw_issue", 0, 0, 0, 0, 0, 0);
        tick(); drive(1, 7, 1, 7, 1, 8, 1, 0, 0);
        expect_o("lu_stall", 0, 0, 1, 0, 0, 0);
        tick();
        expect_o("lu_fwd", 2, 2, 0, 0, 0, 1);

        // x0 destination and unused operands
        tick(); drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
        expect_o("x0_prod", 0, 0, 0, 0, 0, 1);
        tick(); drive(1, 0, 1, 8, 0, 0, 0, 0, 0);
        expect_o("x0_unused", 0, 0, 0, 0, 0, 1);

        // Two writers of x9, youngest wins, then drain
        tick(); drive(1, 0, 0, 0, 0, 9, 1, 0, 0);
        expect_o("x9_w1", 0, 0, 0, 0, 0, 1);
        tick(); drive(1, 9, 1, 0, 0, 9, 1, 0, 0);
        expect_o("x9_w2", 1, 0, 0, 0, 0, 1);
        tick(); drive(1, 9, 1, 9, 1, 0, 0, 0, 0);
        expect_o("x9_multi", 1, 1, 0, 0, 0, 1);
        tick();
        expect_o("x9_young", 2, 2, 0, 0, 0, 1);
        tick();
        expect_o("x9_oldest", 3, 3, 0, 0, 0, 1);
        tick();
        expect_o("x9_drained", 0, 0, 0, 0, 0, 1);

        // Redirect during a load-use stall
        tick(); drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
        expect_o("rd_lw", 0, 0, 0, 0, 0, 1);
        tick(); drive(1, 7, 1, 7, 1, 11, 1, 0, 1);
        expect_o("rd_redir", 0, 0, 0, 1, 0, 1);
        tick(); drive(1, 7, 1, 7, 1, 11, 1, 0, 0);
        expect_o("rd_flush1", 0, 0, 0, 1, 1, 1);
        tick();
        expect_o("rd_flush2", 0, 0, 0, 1, 1, 1);
        tick(); drive(1, 11, 1, 7, 1, 0, 0, 0, 0);
        expect_o("rd_no_entry", 0, 0, 0, 0, 0, 1);

        // Build stall_cnt up to 5
        for (int i = 0; i < 4; i++) begin
            tick(); drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
            expect_o("cnt_lw", 0, 0, 0, 0, 0, 1 + i);
            tick(); drive(1, 7, 1, 7, 1, 8, 1, 0, 0);
            expect_o("cnt_stall", 0, 0, 1, 0, 0, 1 + i);
            tick();
            expect_o("cnt_fwd", 2, 2, 0, 0, 0, 2 + i);
        end

        // Async reset in the middle of a flush
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_o("rst_redir", 0, 0, 0, 1, 0, 5);
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_o("rst_pre", 0, 0, 0, 1, 1, 5);
        tick();
        rst_n = 1'b0;
        #1;
        expect_o("rst_mid", 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        drive(1, 7, 1, 0, 0, 12, 1, 0, 0);
        expect_o("rst_run", 0, 0, 0, 0, 0, 0);
        tick(); drive(1, 12, 1, 0, 0, 0, 0, 0, 0);
        expect_o("rst_fwd", 1, 0, 0, 0, 0, 0);
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations never checked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the pipelined RV32I core, sitting beside the decode stage. It keeps a registered scoreboard of in-flight register writes (EX through WB), picks per-operand forwarding sources, and stalls decode on unready producers such as load-use. It also sequences multi-cycle flushes on control-flow redirects and counts stall cycles for performance monitoring.

## Interface
- NUM_STAGES, 3, tracked write-producing stages after ID (1 = EX … NUM_STAGES = WB), legal 2..6
- LOAD_LAT, 1, extra stages before load data is forwardable; legal 0..NUM_STAGES-1
- FLUSH_CYCLES, 1, bubbles injected into ID after a redirect; legal 1..4
- REG_W, 5, register address width
- SEL_W, $clog2(NUM_STAGES+1), forward select width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_W  source registers
- id_rs1_used, id_rs2_used  in  1  operand actually read
- id_rd  in  REG_W  destination
- id_reg_wr  in  1  instruction writes id_rd
- id_is_load  in  1  instruction is a load
- ex_redirect  in  1  taken branch/jump resolved in EX
- fwd_sel_a, fwd_sel_b  out  SEL_W  0 = register file, k = stage k result
- stall  out  1  hold PC and IF/ID, bubble into EX
- flush  out  1  kill IF/ID contents this cycle
- busy_flush  out  1  FSM in FLUSH
- stall_cnt  out  32  saturating count of stall cycles

## Operation
- Scoreboard: NUM_STAGES entries {v, rd, ld}; entry k = instruction now in stage k.
- Advance each clk: entry k+1 <= entry k; oldest drops out (written to regfile, write-first). Entry 1 <= {id_valid & id_reg_wr & id_rd!=0 & ~stall & ~flush, id_rd, id_is_load}; otherwise a bubble (v=0).
- Match: entry k matches rsX when v, rd==rsX, rsX!=0, rsX_used, id_valid. The youngest (lowest k) match wins.
- Ready: a non-load match is ready at any k≥1; a load match only at k ≥ 1+LOAD_LAT.
- fwd_sel_X = k of the winning match if ready, else 0. It is 0 when stall or flush.
- stall = (any winning match not ready) & state==RUN & ~ex_redirect.
- FSM states RUN, FLUSH.
  - RUN→FLUSH on ex_redirect, loading flush_ctr = FLUSH_CYCLES-1.
  - In FLUSH: flush=1, ID treated invalid; decrement flush_ctr, and return to RUN when it reaches 0.
  - ex_redirect in FLUSH reloads flush_ctr.
- flush = ex_redirect | (state==FLUSH). A redirect overrides stall in the same cycle.
- stall_cnt increments when stall=1 and saturates at 32'hFFFF_FFFF.

## Timing
- Reset (async, rst_n=0): all v=0, state=RUN, flush_ctr=0, stall_cnt=0. Hence fwd_sel_a/b=0, stall=0, flush=0, busy_flush=0 at once.
- fwd_sel_X and stall are combinational from ID inputs plus registered scoreboard, valid in the same cycle. flush is combinational from ex_redirect plus state. busy_flush and stall_cnt are registered.
- Load-use penalty is LOAD_LAT cycles. ALU-to-ALU dependency has zero penalty.
- Reset deasserting mid-stall or mid-flush: the pipeline restarts from empty scoreboard, RUN.
- Redirect while stalled: the stalled ID instruction is killed and never enters the scoreboard.

## Test plan
- ALU→ALU back-to-back: add x5 then sub x6,x5,x1 → fwd_sel_a=1, stall=0. One instruction later → fwd_sel_a=2.
- Load-use, LOAD_LAT=1: lw x7 then add x8,x7,x7 → stall=1 for exactly 1 cycle, then fwd_sel_a=fwd_sel_b=2, stall_cnt=1.
- x0 and unused operands: producer rd=x0, or rs1_used=0 → fwd_sel=0, no stall.
- Multiple writers: x9 written at stages 1 and 2 → fwd_sel=1. Only at stage NUM_STAGES → fwd_sel=NUM_STAGES. After it drains → 0.
- Redirect: ex_redirect during a load-use stall, FLUSH_CYCLES=2 → stall=0, flush=1 for 3 cycles (redirect + 2 FLUSH cycles), busy_flush high for 2 cycles, no scoreboard entry created.
- Async reset asserted mid-FLUSH with stall_cnt=5 → all outputs 0 immediately, state RUN after release.
